vga_write_arbiter: RTL and testbench

- Shares the single vga_adapter pixel-write port between NUM_CLI pixel producers, e.g. the MNIST image blitter, an overlay/text writer and a result-digit painter.
- Arbitration is round-robin, with an optional per-client burst lock so a whole image can be copied uninterrupted.
- A built-in full-screen clear sequencer fills the screen with a solid colour.
- Sits between the producers and vga_adapter; its output is registered, one pixel per cycle.

---
 rtl/vga_pkg.sv | 17 +
 rtl/rr_priority_pick.sv | 37 +++
 rtl/vga_write_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths, screen size and FSM encodings for the VGA write path
//
// Purpose: common constants for the VGA write arbiter and its helpers.
// Ports: none (package).
package vga_pkg;

  localparam int VGA_X_W = 10;
  localparam int VGA_Y_W = 9;
  localparam int VGA_C_W = 9;

  localparam logic [VGA_X_W-1:0] SCREEN_W_DEF = 10'd640;
  localparam logic [VGA_Y_W-1:0] SCREEN_H_DEF = 9'd480;

  localparam logic [0:0] S_ARB   = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin picker
//
// Purpose: pick the first asserted request after ptr_i, wrapping modulo N.
// Ports:
//   req_i   - request vector
//   ptr_i   - index of the previous winner (search starts at ptr_i+1)
//   grant_o - one-hot grant, all zero when no request
//   idx_o   - index of the granted request
//   any_o   - at least one request present
module rr_priority_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   ptr_i,
  output logic [N-1:0] grant_o,
  output logic [1:0]   idx_o,
  output logic         any_o
);

  int cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = 2'(cand);
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - round-robin pixel-write arbiter with burst lock and screen clear
//
// Purpose: share the single vga_adapter write port between NUM_CLI producers,
// with an optional per-client burst lock and a built-in solid-colour clear sweep.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   cli_valid/cli_lock    - per-client pixel pending / burst ownership request
//   cli_x/cli_y/cli_color - per-client packed pixel data
//   cli_ready             - one-hot grant (transfer on valid & ready)
//   clear_start/color     - full-screen clear request (level) and fill colour
//   clear_busy            - sweep in progress
//   vga_x/y/color/write   - registered pixel write to vga_adapter
//   active_id             - index of the last granted client
module vga_write_arbiter
  import vga_pkg::*;
#(
  parameter int                 NUM_CLI  = 3,
  parameter logic [VGA_X_W-1:0] SCREEN_W = SCREEN_W_DEF,
  parameter logic [VGA_Y_W-1:0] SCREEN_H = SCREEN_H_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CLI-1:0]         cli_valid,
  input  logic [NUM_CLI-1:0]         cli_lock,
  input  logic [VGA_X_W*NUM_CLI-1:0] cli_x,
  input  logic [VGA_Y_W*NUM_CLI-1:0] cli_y,
  input  logic [VGA_C_W*NUM_CLI-1:0] cli_color,
  output logic [NUM_CLI-1:0]         cli_ready,
  input  logic                       clear_start,
  input  logic [VGA_C_W-1:0]         clear_color,
  output logic                       clear_busy,
  output logic [VGA_X_W-1:0]         vga_x,
  output logic [VGA_Y_W-1:0]         vga_y,
  output logic [VGA_C_W-1:0]         vga_color,
  output logic                       vga_write,
  output logic [1:0]                 active_id
);

  logic [0:0]         state_q, state_d;
  logic               lock_valid_q, lock_valid_d;
  logic [1:0]         lock_owner_q, lock_owner_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         active_id_q, active_id_d;
  logic [VGA_X_W-1:0] sweep_x_q, sweep_x_d;
  logic [VGA_Y_W-1:0] sweep_y_q, sweep_y_d;
  logic [VGA_C_W-1:0] fill_q, fill_d;
  logic [VGA_X_W-1:0] vga_x_q, vga_x_d;
  logic [VGA_Y_W-1:0] vga_y_q, vga_y_d;
  logic [VGA_C_W-1:0] vga_c_q, vga_c_d;
  logic               vga_we_q, vga_we_d;

  logic [NUM_CLI-1:0] owner_mask, pick_req, pick_grant;
  logic               owner_lock, pick_any, clear_go, grant_en, xfer, sel_lock;
  logic [1:0]         pick_idx;
  logic [VGA_X_W-1:0] sel_x;
  logic [VGA_Y_W-1:0] sel_y;
  logic [VGA_C_W-1:0] sel_c;

  always_comb begin
    owner_mask = '0;
    owner_lock = 1'b0;
    for (int i = 0; i < NUM_CLI; i++) begin
      if (lock_owner_q == 2'(i)) begin
        owner_mask[i] = 1'b1;
        owner_lock    = cli_lock[i];
      end
    end
  end

  // While a burst is locked only the owner may compete, so the picker
  // either returns the owner or nothing.
  assign pick_req = lock_valid_q ? (cli_valid & owner_mask) : cli_valid;

  rr_priority_pick #(.N(NUM_CLI)) u_pick (
    .req_i   (pick_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // A pending clear beats any client in the same cycle, unless a lock is held.
  assign clear_go  = (state_q == S_ARB) && !lock_valid_q && clear_start;
  assign grant_en  = !reset && (state_q == S_ARB) && !clear_go;
  assign cli_ready = grant_en ? pick_grant : '0;
  assign xfer      = grant_en && pick_any;

  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_c    = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_CLI; i++) begin
      if (pick_idx == 2'(i)) begin
        sel_x    = cli_x[i*VGA_X_W +: VGA_X_W];
        sel_y    = cli_y[i*VGA_Y_W +: VGA_Y_W];
        sel_c    = cli_color[i*VGA_C_W +: VGA_C_W];
        sel_lock = cli_lock[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    rr_ptr_d     = rr_ptr_q;
    active_id_d  = active_id_q;
    sweep_x_d    = sweep_x_q;
    sweep_y_d    = sweep_y_q;
    fill_d       = fill_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_c_d      = vga_c_q;
    vga_we_d     = 1'b0;
    if (state_q == S_CLEAR) begin
      vga_x_d  = sweep_x_q;
      vga_y_d  = sweep_y_q;
      vga_c_d  = fill_q;
      vga_we_d = 1'b1;
      if (sweep_x_q == SCREEN_W - 1'b1) begin
        sweep_x_d = '0;
        if (sweep_y_q == SCREEN_H - 1'b1) begin
          state_d = S_ARB;
        end else begin
          sweep_y_d = sweep_y_q + 1'b1;
        end
      end else begin
        sweep_x_d = sweep_x_q + 1'b1;
      end
    end else if (clear_go) begin
      state_d   = S_CLEAR;
      fill_d    = clear_color;
      sweep_x_d = '0;
      sweep_y_d = '0;
    end else begin
      if (xfer) begin
        vga_x_d     = sel_x;
        vga_y_d     = sel_y;
        vga_c_d     = sel_c;
        vga_we_d    = 1'b1;
        rr_ptr_d    = pick_idx;
        active_id_d = pick_idx;
      end
      // The owner keeps exclusivity through the cycle its lock drops.
      if (lock_valid_q) begin
        if (!owner_lock) lock_valid_d = 1'b0;
      end else if (xfer && sel_lock) begin
        lock_valid_d = 1'b1;
        lock_owner_d = pick_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_ARB;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      rr_ptr_q     <= 2'(NUM_CLI - 1);
      active_id_q  <= '0;
      sweep_x_q    <= '0;
      sweep_y_q    <= '0;
      fill_q       <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_c_q      <= '0;
      vga_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      rr_ptr_q     <= rr_ptr_d;
      active_id_q  <= active_id_d;
      sweep_x_q    <= sweep_x_d;
      sweep_y_q    <= sweep_y_d;
      fill_q       <= fill_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_c_q      <= vga_c_d;
      vga_we_q     <= vga_we_d;
    end
  end

  assign clear_busy = (state_q == S_CLEAR);
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_color  = vga_c_q;
  assign vga_write  = vga_we_q;
  assign active_id  = active_id_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb/tb_vga_write_arbiter.sv - self-checking bench for vga_write_arbiter
module tb_vga_write_arbiter;

  localparam int NC = 3;
  localparam int W  = 8;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NC-1:0] cli_valid = '0;
  logic [NC-1:0] cli_lock = '0;
  logic [29:0]   cli_x = '0;
  logic [26:0]   cli_y = '0;
  logic [26:0]   cli_color = '0;
  logic [NC-1:0] cli_ready;
  logic          clear_start = 1'b0;
  logic [8:0]    clear_color = '0;
  logic          clear_busy;
  logic [9:0]    vga_x;
  logic [8:0]    vga_y;
  logic [8:0]    vga_color;
  logic          vga_write;
  logic [1:0]    active_id;

  vga_write_arbiter #(.NUM_CLI(NC), .SCREEN_W(10'd8), .SCREEN_H(9'd4)) dut (
    .clk(clk), .reset(reset), .cli_valid(cli_valid), .cli_lock(cli_lock),
    .cli_x(cli_x), .cli_y(cli_y), .cli_color(cli_color), .cli_ready(cli_ready),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_write(vga_write),
    .active_id(active_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit   m_init = 0;
  int   m_owner = -1;
  int   m_last = NC - 1;
  int   m_left = 0;
  int   m_fill = 0;
  int   m_active = 0;
  int   m_write = 0, m_x = 0, m_y = 0, m_c = 0;

  function automatic logic [NC-1:0] exp_ready();
    int c;
    if (reset || m_left > 0) return '0;
    if (m_owner >= 0) return cli_valid[m_owner] ? NC'(1 << m_owner) : '0;
    if (clear_start) return '0;
    for (int k = 1; k <= NC; k++) begin
      c = (m_last + k) % NC;
      if (cli_valid[c]) return NC'(1 << c);
    end
    return '0;
  endfunction

  always @(posedge clk) begin
    logic [NC-1:0] g;
    int gi, p;
    g = exp_ready();
    if (reset) begin
      m_init = 1; m_owner = -1; m_last = NC - 1; m_left = 0; m_fill = 0;
      m_active = 0; m_write = 0; m_x = 0; m_y = 0; m_c = 0;
    end else begin
      m_write = 0;
      if (m_left > 0) begin
        p = W * H - m_left;
        m_x = p % W; m_y = p / W; m_c = m_fill; m_write = 1;
        m_left--;
      end else if (m_owner < 0 && clear_start) begin
        m_left = W * H;
        m_fill = int'(clear_color);
      end else begin
        gi = -1;
        for (int i = 0; i < NC; i++) if (g[i]) gi = i;
        if (gi >= 0) begin
          m_x = int'(cli_x[gi*10 +: 10]);
          m_y = int'(cli_y[gi*9 +: 9]);
          m_c = int'(cli_color[gi*9 +: 9]);
          m_write = 1; m_last = gi; m_active = gi;
        end
        if (m_owner >= 0) begin
          if (!cli_lock[m_owner]) m_owner = -1;
        end else if (gi >= 0 && cli_lock[gi]) begin
          m_owner = gi;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("ready", int'(cli_ready), int'(exp_ready()));
      chk("vga_write", int'(vga_write), m_write);
      chk("vga_x", int'(vga_x), m_x);
      chk("vga_y", int'(vga_y), m_y);
      chk("vga_color", int'(vga_color), m_c);
      chk("clear_busy", int'(clear_busy), (m_left > 0) ? 1 : 0);
      chk("active_id", int'(active_id), m_active);
    end
  end

  // ---------------- stimulus ----------------
  logic [NC-1:0] fired = '0;

  task automatic new_data(input int i);
    cli_x[i*10 +: 10]    = 10'($urandom_range(0, 1023));
    cli_y[i*9 +: 9]      = 9'($urandom_range(0, 511));
    cli_color[i*9 +: 9]  = 9'($urandom_range(0, 511));
  endtask

  // Drive one cycle at posedge+1, record valid&ready at posedge+3.
  task automatic cyc(input logic [NC-1:0] v, input logic [NC-1:0] l, input logic cs);
    @(posedge clk); #1;
    for (int i = 0; i < NC; i++) if (fired[i] || !cli_valid[i]) new_data(i);
    cli_valid = v; cli_lock = l; clear_start = cs;
    #2;
    fired = cli_valid & cli_ready;
  endtask

  int nw, nb, bad, got, grant_seen;
  logic [9:0] cap_x;
  logic [NC-1:0] nv, nl;

  initial begin
    for (int i = 0; i < NC; i++) new_data(i);
    // reset
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);
    chk("reset_write", int'(vga_write), 0);
    chk("reset_busy", int'(clear_busy), 0);
    chk("reset_active", int'(active_id), 0);
    chk("reset_x", int'(vga_x), 0);
    chk("reset_ready", int'(cli_ready), 0);
    reset = 1'b0;

    // round robin with all clients valid
    cap_x = '0;
    for (int k = 0; k < 6; k++) begin
      cyc(3'b111, '0, 1'b0);
      if (k > 0) begin
        chk("rr_pixel_x", int'(vga_x), int'(cap_x));
        chk("rr_write", int'(vga_write), 1);
      end
      chk("rr_grant", int'(fired), 1 << (k % 3));
      cap_x = cli_x[(k % 3)*10 +: 10];
    end

    // burst lock by client 1
    cyc(3'b010, 3'b010, 1'b0);
    chk("lock_first", int'(fired), 3'b010);
    for (int k = 0; k < 4; k++) begin
      cyc(3'b111, 3'b010, 1'b0);
      chk("lock_hold", int'(fired), 3'b010);
    end
    cyc(3'b101, 3'b000, 1'b0);
    chk("lock_release_cycle", int'(fired), 0);
    cyc(3'b111, 3'b000, 1'b0);
    chk("after_lock", int'(fired), 3'b100);
    cyc('0, '0, 1'b0);

    // clear races client 0, clear wins
    clear_color = 9'h1FF;
    cyc(3'b001, '0, 1'b1);
    chk("clear_wins", int'(fired), 0);
    nw = 0; nb = 0; bad = 0; got = 0; grant_seen = 0;
    for (int t = 0; t < 60 && got == 0; t++) begin
      cyc(3'b001, '0, 1'b0);
      if (clear_busy) nb++;
      if (clear_busy && cli_ready != 0) bad++;
      if (vga_write) begin
        if (vga_x != 10'(nw % W) || vga_y != 9'(nw / W) || vga_color != 9'h1FF) bad++;
        nw++;
      end
      if (fired != 0) begin got = 1; grant_seen = int'(fired); end
    end
    chk("clear_writes", nw, 32);
    chk("clear_busy_cycles", nb, 32);
    chk("clear_raster_errors", bad, 0);
    chk("clear_then_grant", got, 1);
    chk("clear_first_grant", grant_seen, 3'b001);

    // clear deferred by a lock
    cyc(3'b001, 3'b001, 1'b0);
    chk("deferred_lock_grant", int'(fired), 3'b001);
    cyc('0, 3'b001, 1'b1);
    cyc('0, 3'b001, 1'b1);
    chk("deferred_busy", int'(clear_busy), 0);
    cyc('0, '0, 1'b1);
    chk("deferred_release", int'(clear_busy), 0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
    chk("clear_after_unlock", int'(clear_busy), 1);

    // reset in the middle of the sweep at pixel 10
    got = 0;
    for (int t = 0; t < 20 && got == 0; t++) begin
      cyc('0, '0, 1'b0);
      if (vga_write && vga_x == 10'd2 && vga_y == 9'd1) got = 1;
    end
    chk("reached_pixel10", got, 1);
    reset = 1'b1;
    cyc('0, '0, 1'b0);
    chk("midclear_reset_write", int'(vga_write), 0);
    chk("midclear_reset_busy", int'(clear_busy), 0);
    chk("midclear_reset_xyc", int'(vga_x) + int'(vga_y) + int'(vga_color), 0);
    reset = 1'b0;
    cyc(3'b111, '0, 1'b0);
    chk("post_reset_grant", int'(fired), 3'b001);

    // randomized traffic checked by the model
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < NC; i++) begin
        nv[i] = (cli_valid[i] && !fired[i]) ? 1'b1 : ($urandom_range(0, 2) != 0);
        nl[i] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 9) == 0) clear_color = 9'($urandom_range(0, 511));
      cyc(nv, nl, $urandom_range(0, 59) == 0);
    end
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
